eh2_exu_mul_arb: RTL

Two-thread arbiter and in-flight tracker for the shared 3-stage pipelined integer multiplier in the EH2 execute unit.
- Each cycle it selects at most one of two per-thread multiply requests, with round-robin on conflict, and drives the multiplier issue packet.
- It carries thread id and destination tag alongside the multiplier pipeline, caps outstanding operations per thread, and kills in-flight operations on a per-thread flush.
- It returns each result tagged with its thread and destination.

---
 rtl/eh2_exu_mul_arb.sv | 135 +++++++++++++
 1 files changed

// File: rtl/eh2_exu_mul_arb.sv
// Two-thread arbiter and in-flight tracker for the shared pipelined multiplier.
// Ports: clk/rst_l, per-thread req_*/req_ready/flush, mul_* issue, mul_out in, res_* out.
module eh2_exu_mul_arb #(
  parameter int TAG_W   = 5,
  parameter int LAT     = 3,
  parameter int MAX_OUT = 2
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic [1:0]           req_valid,
  input  logic [63:0]          req_a,
  input  logic [63:0]          req_b,
  input  logic [1:0]           req_rs1_sign,
  input  logic [1:0]           req_rs2_sign,
  input  logic [1:0]           req_low,
  input  logic [2*TAG_W-1:0]   req_tag,
  output logic [1:0]           req_ready,
  input  logic [1:0]           flush,
  output logic                 mul_valid,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  output logic                 mul_rs1_sign,
  output logic                 mul_rs2_sign,
  output logic                 mul_low,
  input  logic [31:0]          mul_out,
  output logic                 res_valid,
  output logic                 res_tid,
  output logic [TAG_W-1:0]     res_tag,
  output logic [31:0]          res_data
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_OUT);

  logic                r_last;
  logic [CW-1:0]       r_cnt [2];
  logic [LAT:1]        r_v;
  logic [LAT:1]        r_tid;
  logic [TAG_W-1:0]    r_tag [1:LAT];

  logic [1:0]          w_elig;
  logic [1:0]          w_gnt;
  logic                w_gtid;
  logic [TAG_W-1:0]    w_gtag;
  logic                w_res_valid;
  logic [1:0]          w_dec;

  always_comb begin
    for (int t = 0; t < 2; t++) begin
      w_elig[t] = req_valid[t] & ~flush[t] & (r_cnt[t] < CMAX) & rst_l;
    end
    w_gnt = w_elig;
    // On a tie the thread that did not win last time goes first.
    if (&w_elig) begin
      w_gnt = r_last ? 2'b01 : 2'b10;
    end
  end

  assign w_gtid    = w_gnt[1];
  assign w_gtag    = w_gtid ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
  assign req_ready = w_gnt;

  assign mul_valid    = |w_gnt;
  assign mul_a        = w_gtid ? req_a[63:32] : req_a[31:0];
  assign mul_b        = w_gtid ? req_b[63:32] : req_b[31:0];
  assign mul_rs1_sign = req_rs1_sign[w_gtid];
  assign mul_rs2_sign = req_rs2_sign[w_gtid];
  assign mul_low      = req_low[w_gtid];

  // Last stage can still hold stale valids in the reset cycle itself.
  assign w_res_valid = rst_l & r_v[LAT] & ~flush[r_tid[LAT]];
  assign res_valid   = w_res_valid;
  assign res_tid     = r_tid[LAT];
  assign res_tag     = r_tag[LAT];
  assign res_data    = mul_out;

  always_comb begin
    for (int t = 0; t < 2; t++) begin
      w_dec[t] = w_res_valid & (r_tid[LAT] == t[0]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_last <= 1'b1;
    end else if (|w_gnt) begin
      r_last <= w_gtid;
    end
  end

  // Stage valids: flushed threads are killed as they shift.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_v <= '0;
    end else begin
      r_v[1] <= |w_gnt;
      for (int k = 2; k <= LAT; k++) begin
        r_v[k] <= r_v[k-1] & ~flush[r_tid[k-1]];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_tid[1] <= w_gtid;
    r_tag[1] <= w_gtag;
    for (int k = 2; k <= LAT; k++) begin
      r_tid[k] <= r_tid[k-1];
      r_tag[k] <= r_tag[k-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int t = 0; t < 2; t++) begin
      if (!rst_l || flush[t]) begin
        r_cnt[t] <= '0;
      end else begin
        case ({w_gnt[t], w_dec[t]})
          2'b10:   r_cnt[t] <= r_cnt[t] + CW'(1);
          2'b01:   r_cnt[t] <= r_cnt[t] - CW'(1);
          default: r_cnt[t] <= r_cnt[t];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_l) begin
      for (int t = 0; t < 2; t++) begin
        assert (!(w_gnt[t] && !w_dec[t] && r_cnt[t] == CMAX));
        assert (!(w_dec[t] && !w_gnt[t] && r_cnt[t] == '0));
      end
    end
  end

endmodule
